vga_dac_feeder: RTL

VGA_DAC_FEEDER -- requirements
Module: vga_dac_feeder

---
 rtl/vga_dac_pkg.sv | 61 ++++++
 rtl/vga_timing.sv | 77 +++++++
 rtl/vga_dac_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_dac_pkg.sv
// Shared VGA timing defaults, pattern-mode encoding and the per-pixel
// pattern function used by the DAC feeder.
package vga_dac_pkg;

  localparam int H_VIS_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_VIS_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;
  localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 12;
  localparam int BAR_W = 80;

  typedef enum logic [2:0] {
    MODE_HGRAD  = 3'd0,
    MODE_VGRAD  = 3'd1,
    MODE_XOR    = 3'd2,
    MODE_BARS   = 3'd3,
    MODE_SCROLL = 3'd4
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Unlisted mode codes fall through to full white.
  function automatic rgb_t patternPixel(input logic [2:0] modeSel,
                                        input logic [CNT_W-1:0] h,
                                        input logic [7:0] v8,
                                        input logic [7:0] f);
    rgb_t pix;
    logic [2:0] bar;
    pix = '0;
    bar = 3'(h / CNT_W'(BAR_W));
    case (modeSel)
      MODE_HGRAD:  pix.r = h[7:0];
      MODE_VGRAD:  pix.g = v8;
      MODE_XOR: begin
        pix.r = h[7:0] ^ v8;
        pix.g = pix.r;
        pix.b = pix.r;
      end
      MODE_BARS: begin
        pix.r = {8{bar[2]}};
        pix.g = {8{bar[1]}};
        pix.b = {8{bar[0]}};
      end
      MODE_SCROLL: pix.g = h[7:0] + f;
      default:     pix = '1;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters, frame counter and raw (unpipelined)
// sync/blank decode for one VGA raster.
module vga_timing
  import vga_dac_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic [7:0]       f_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             hblank_o,
  output logic             vblank_o
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VIS - 1);
  localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hCnt_q, hCnt_d;
  logic [CNT_W-1:0] vCnt_q, vCnt_d;
  logic [7:0]       frame_q, frame_d;

  // The frame counter steps as the last visible line ends, so the new value
  // is already stable throughout vertical blanking before the next frame.
  always_comb begin
    hCnt_d  = hCnt_q + ONE;
    vCnt_d  = vCnt_q;
    frame_d = frame_q;
    if (hCnt_q == H_LAST) begin
      hCnt_d = '0;
      vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + ONE;
      if (vCnt_q == V_VIS_LAST) frame_d = frame_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hCnt_q  <= '0;
      vCnt_q  <= '0;
      frame_q <= '0;
    end else begin
      hCnt_q  <= hCnt_d;
      vCnt_q  <= vCnt_d;
      frame_q <= frame_d;
    end
  end

  assign h_o      = hCnt_q;
  assign v_o      = vCnt_q;
  assign f_o      = frame_q;
  assign hsync_o  = !((hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST));
  assign vsync_o  = !((vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST));
  assign hblank_o = (hCnt_q >= H_VIS_C);
  assign vblank_o = (vCnt_q >= V_VIS_C);

endmodule

// File: rtl/vga_dac_feeder.sv
// VGA test-pattern source: frame-aligned mode latch, pattern stage and a
// registered output stage feeding true/complement DAC inputs.
module vga_dac_feeder
  import vga_dac_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [7:0] rn,
  output logic [7:0] gn,
  output logic [7:0] bn,
  output logic       r7,
  output logic       g7,
  output logic       b7,
  output logic       r6,
  output logic       g6,
  output logic       b6
);

  logic [CNT_W-1:0] hCnt, vCnt;
  logic [7:0]       frameCnt;
  logic             hsyncRaw, vsyncRaw, hblankRaw, vblankRaw;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) uTiming (
    .clk_i   (clk),
    .rst_i   (rst),
    .h_o     (hCnt),
    .v_o     (vCnt),
    .f_o     (frameCnt),
    .hsync_o (hsyncRaw),
    .vsync_o (vsyncRaw),
    .hblank_o(hblankRaw),
    .vblank_o(vblankRaw)
  );

  logic [2:0] modeLatched_q, modeLatched_d;
  rgb_t       pix1_q, pix1_d;
  logic       hsync1_q, vsync1_q, hblank1_q, vblank1_q;
  rgb_t       pix2_q, pix2_d;
  rgb_t       pixN_q;
  logic       hsync2_q, vsync2_q, hblank2_q, vblank2_q;
  logic       r7_q, g7_q, b7_q, r6_q, g6_q, b6_q;

  // The first pixel of a frame already uses the newly sampled mode, so a
  // whole frame is always rendered in a single mode.
  always_comb begin
    modeLatched_d = modeLatched_q;
    if ((hCnt == '0) && (vCnt == '0)) modeLatched_d = mode;
    pix1_d = patternPixel(modeLatched_d, hCnt, vCnt[7:0], frameCnt);
    pix2_d = (hblank1_q || vblank1_q) ? '0 : pix1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modeLatched_q <= '0;
      pix1_q        <= '0;
      hsync1_q      <= 1'b1;
      vsync1_q      <= 1'b1;
      hblank1_q     <= 1'b0;
      vblank1_q     <= 1'b0;
      pix2_q        <= '0;
      pixN_q        <= '1;
      hsync2_q      <= 1'b1;
      vsync2_q      <= 1'b1;
      hblank2_q     <= 1'b0;
      vblank2_q     <= 1'b0;
      r7_q          <= 1'b0;
      g7_q          <= 1'b0;
      b7_q          <= 1'b0;
      r6_q          <= 1'b0;
      g6_q          <= 1'b0;
      b6_q          <= 1'b0;
    end else begin
      modeLatched_q <= modeLatched_d;
      pix1_q        <= pix1_d;
      hsync1_q      <= hsyncRaw;
      vsync1_q      <= vsyncRaw;
      hblank1_q     <= hblankRaw;
      vblank1_q     <= vblankRaw;
      pix2_q        <= pix2_d;
      pixN_q        <= ~pix2_d;
      hsync2_q      <= hsync1_q;
      vsync2_q      <= vsync1_q;
      hblank2_q     <= hblank1_q;
      vblank2_q     <= vblank1_q;
      r7_q          <= pix2_d.r[7];
      g7_q          <= pix2_d.g[7];
      b7_q          <= pix2_d.b[7];
      r6_q          <= pix2_d.r[6];
      g6_q          <= pix2_d.g[6];
      b6_q          <= pix2_d.b[6];
    end
  end

  // Complements and MSB copies have their own flops so every DAC pin
  // switches on the same clock edge with no gate in between.
  assign hsync  = hsync2_q;
  assign vsync  = vsync2_q;
  assign hblank = hblank2_q;
  assign vblank = vblank2_q;
  assign r      = pix2_q.r;
  assign g      = pix2_q.g;
  assign b      = pix2_q.b;
  assign rn     = pixN_q.r;
  assign gn     = pixN_q.g;
  assign bn     = pixN_q.b;
  assign r7     = r7_q;
  assign g7     = g7_q;
  assign b7     = b7_q;
  assign r6     = r6_q;
  assign g6     = g6_q;
  assign b6     = b6_q;

endmodule
